// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the sram-like data-port responder.
// Request size codes, the response entry payload, byte-lane decode and misalignment rules.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // extra holds the per-request additional latency; it stays zero when random stalls are off
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  extra;
  } resp_entry_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << addr_lo;
      SIZE_HALF: return 4'b0011 << addr_lo;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response FIFO: each entry ages from 1 up to DELAY+extra and the head is ready
// once its age reaches that target. Age counters saturate at the target.
module sram_like_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DELAY = 2,
  parameter int AGE_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  resp_entry_t            push_entry_i,
  input  logic                   pop_i,
  output logic                   head_ready_o,
  output logic [31:0]            head_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]      data_q   [DEPTH];
  logic [1:0]       extra_q  [DEPTH];
  logic [AGE_W-1:0] age_q    [DEPTH];
  logic [AGE_W-1:0] target   [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      target[i] = AGE_W'(DELAY) + AGE_W'(extra_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      data_q[wr_ptr_q]  <= push_entry_i.data;
      extra_q[wr_ptr_q] <= push_entry_i.extra;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_i && !pop_i)      count_q <= count_q + (PW+1)'(1);
      else if (pop_i && !push_i) count_q <= count_q - (PW+1)'(1);
      // a fresh entry starts at 1 so that a target of DELAY lands data_ok at accept+DELAY
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && wr_ptr_q == PW'(i))  age_q[i] <= AGE_W'(1);
        else if (age_q[i] != target[i])   age_q[i] <= age_q[i] + AGE_W'(1);
      end
    end
  end

  assign head_ready_o = (count_q != '0) && (age_q[rd_ptr_q] == target[rd_ptr_q]);
  assign head_data_o  = data_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/sram_like_slave_resp.sv
// Memory-side responder of the sram-like data port: RAM, accept logic, sticky error flag.
// Optional SRAM_LIKE_RANDSTALL_EN adds an LFSR that throttles addr_ok and stretches latency.
module sram_like_slave_resp
  import sram_like_pkg::*;
#(
  parameter int MEM_AW    = 12,
  parameter int DELAY     = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

`ifdef SRAM_LIKE_RANDSTALL_EN
  localparam int EXTRA_MAX = 3;
`else
  localparam int EXTRA_MAX = 0;
`endif
  localparam int AGE_W = $clog2(DELAY + EXTRA_MAX + 1);
  localparam int CW    = $clog2(MAX_OUTST) + 1;

  logic [31:0]       ram_q [2**MEM_AW];
  logic [MEM_AW-1:0] word_idx;
  logic [31:0]       rd_word;
  logic [3:0]        be;
  logic              bad;
  logic              accept;
  logic              stall;
  logic [1:0]        extra;
  logic [CW-1:0]     count;
  logic              head_ready;
  logic [31:0]       head_data;
  resp_entry_t       push_entry;
  logic              data_ok_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              err_d;
  logic              unused_addr;

  assign unused_addr = ^addr_i[31:MEM_AW+2];

`ifdef SRAM_LIKE_RANDSTALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
  assign extra = lfsr_q[3:2];
`else
  assign stall = 1'b0;
  assign extra = 2'b00;
`endif

  // count is registered, so a pop on this edge does not open a slot until next cycle
  assign addr_ok_o = ~rst_i & (count < CW'(MAX_OUTST)) & ~stall;
  assign accept    = req_i & addr_ok_o;

  assign word_idx = addr_i[MEM_AW+1:2];
  assign bad      = misaligned(size_i, addr_i[1:0]);
  assign be       = bad ? 4'b0000 : byte_en(size_i, addr_i[1:0]);
  assign rd_word  = ram_q[word_idx];

  always_ff @(posedge clk_i) begin
    if (accept && wr_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign push_entry.data  = wr_i ? 32'h0 : rd_word;
  assign push_entry.extra = extra;

  sram_like_resp_fifo #(
    .DEPTH (MAX_OUTST),
    .DELAY (DELAY),
    .AGE_W (AGE_W)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .pop_i        (head_ready),
    .head_ready_o (head_ready),
    .head_data_o  (head_data),
    .count_o      (count)
  );

  assign err_d = err_q | (accept & bad);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      data_ok_q <= head_ready;
      if (head_ready) rdata_q <= head_data;
      err_q     <= err_d;
    end
  end

  assign data_ok_o = data_ok_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_sram_like_slave_resp.sv
// Self-checking bench for sram_like_slave_resp against a queue/array reference model.
// DELAY=4 lets MAX_OUTST requests be in flight at once so the full FIFO is reachable.
module tb_sram_like_slave_resp;

  localparam int MEM_AW    = 6;
  localparam int DELAY     = 4;
  localparam int MAX_OUTST = 4;
  localparam int NWORDS    = 1 << MEM_AW;

  logic        clk = 1'b0;
  logic        rst, req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok, err;

  always #5 clk = ~clk;

  sram_like_slave_resp #(
    .MEM_AW    (MEM_AW),
    .DELAY     (DELAY),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .wr_i      (wr),
    .size_i    (size),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .addr_ok_o (addr_ok),
    .data_ok_o (data_ok),
    .rdata_o   (rdata),
    .err_o     (err)
  );

  typedef struct { logic [31:0] data; int due; } exp_t;
  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  exp_t        mq[$];
  logic [31:0] mem [NWORDS];
  logic        m_err = 1'b0;
  int          edge_n = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        last_acc;
  int          pulse_edges[$];
  logic [31:0] pulse_data[$];
  vec_t        tbl[10];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic void fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (edge %0d)", name, edge_n);
  endfunction

  // Reference: byte range [lo, lo+n) is written when the size divides the offset.
  function automatic void model_op(input logic w, input logic [1:0] s, input logic [31:0] a,
                                   input logic [31:0] d);
    int idx, lo, nb;
    bit bad;
    exp_t e;
    idx = int'((a >> 2) % NWORDS);
    lo  = int'(a % 4);
    nb  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    bad = (s == 2'd3) || (lo % nb != 0);
    if (bad) m_err = 1'b1;
    if (w && !bad)
      for (int b = lo; b < lo + nb; b++) mem[idx][8*b +: 8] = d[8*b +: 8];
    e.data = w ? 32'h0 : mem[idx];
    e.due  = edge_n + DELAY;
    mq.push_back(e);
  endfunction

  task automatic step(input logic r, input logic q, input logic w, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] d);
    logic exp_aok, exp_dok;
    rst = r; req = q; wr = w; size = s; addr = a; wdata = d;
    #1;
    exp_aok = !r && (mq.size() < MAX_OUTST);
`ifdef SRAM_LIKE_RANDSTALL_EN
    if (!exp_aok) check("addr_ok_blocked", addr_ok, 1'b0);
    last_acc = q && addr_ok && exp_aok;
`else
    check("addr_ok", addr_ok, exp_aok);
    last_acc = q && exp_aok;
`endif
    @(posedge clk);
    edge_n++;
    if (r) begin
      mq.delete();
      m_err = 1'b0;
    end else if (last_acc) begin
      model_op(w, s, a, d);
    end
    @(negedge clk);
`ifdef SRAM_LIKE_RANDSTALL_EN
    exp_dok = data_ok && (mq.size() > 0);
    if (data_ok) check("data_ok_has_entry", mq.size() > 0, 1'b1);
`else
    exp_dok = !r && (mq.size() > 0) && (mq[0].due == edge_n);
    check("data_ok", data_ok, exp_dok);
`endif
    if (data_ok) begin
      pulse_edges.push_back(edge_n);
      pulse_data.push_back(rdata);
    end
    if (exp_dok) begin
      check("rdata", rdata, mq[0].data);
      void'(mq.pop_front());
    end
    check("err", err, m_err);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    do begin
      step(1'b0, 1'b1, w, s, a, d);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) fail("issue_accept");
  endtask

  task automatic drain();
    int n = 0;
    while (mq.size() > 0 && n < 60) begin
      idle();
      n++;
    end
    if (mq.size() > 0) fail("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_w, t_r, stalls, accepted, n;
    tbl[0] = '{2'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{2'd0, 32'h0000_1002, 32'h00AA_0000, 32'h11AA_3344, 1'b0};
    tbl[2] = '{2'd0, 32'h0000_1000, 32'h0000_00CC, 32'h1122_33CC, 1'b0};
    tbl[3] = '{2'd0, 32'h0000_1003, 32'h5500_0000, 32'h5522_3344, 1'b0};
    tbl[4] = '{2'd1, 32'h0000_1000, 32'h0000_BEEF, 32'h1122_BEEF, 1'b0};
    tbl[5] = '{2'd1, 32'h0000_1002, 32'hCAFE_0000, 32'hCAFE_3344, 1'b0};
    tbl[6] = '{2'd1, 32'h0000_1003, 32'hFFFF_0000, 32'h1122_3344, 1'b1};
    tbl[7] = '{2'd2, 32'h0000_1002, 32'hFFFF_FFFF, 32'h1122_3344, 1'b1};
    tbl[8] = '{2'd3, 32'h0000_1000, 32'hFFFF_FFFF, 32'h1122_3344, 1'b1};
    tbl[9] = '{2'd1, 32'h0000_1001, 32'hFFFF_FFFF, 32'h1122_3344, 1'b1};

    // reset held with req high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 2'd2, 32'h1000, 32'h1234_5678);
    check("rdata_after_rst", rdata, 32'h0);
    check("data_ok_after_rst", data_ok, 1'b0);

    for (int i = 0; i < NWORDS; i++) issue(1'b1, 2'd2, i * 4, $urandom);
    drain();

    // write then read back-to-back
    pulse_edges.delete(); pulse_data.delete();
    issue(1'b1, 2'd2, 32'h1000, 32'hDEAD_BEEF);
    t_w = edge_n;
    issue(1'b0, 2'd2, 32'h1000, 32'h0);
    t_r = edge_n;
    drain();
    check("b2b_pulses", pulse_edges.size(), 2);
    if (pulse_edges.size() == 2) begin
      check("b2b_read_data", pulse_data[1], 32'hDEAD_BEEF);
`ifndef SRAM_LIKE_RANDSTALL_EN
      check("b2b_accept_gap", t_r - t_w, 1);
      check("b2b_first_edge", pulse_edges[0] - t_w, DELAY);
      check("b2b_second_edge", pulse_edges[1] - t_w, DELAY + 1);
`endif
    end

    // byte-lane table, each from a clean reset over 0x11223344
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      pulse_data.delete(); pulse_edges.delete();
      issue(1'b1, 2'd2, 32'h1000, 32'h1122_3344);
      issue(1'b1, tbl[k].size, tbl[k].addr, tbl[k].wdata);
      issue(1'b0, 2'd2, 32'h1000, 32'h0);
      drain();
      check($sformatf("tbl%0d_pulses", k), pulse_data.size(), 3);
      if (pulse_data.size() == 3) check($sformatf("tbl%0d_word", k), pulse_data[2], tbl[k].exp_word);
      check($sformatf("tbl%0d_err", k), err, tbl[k].exp_err);
    end

    // fill: five reads with req held
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    pulse_data.delete(); pulse_edges.delete();
    stalls = 0; accepted = 0; n = 0;
    while (accepted < 5 && n < 40) begin
      step(1'b0, 1'b1, 1'b0, 2'd2, accepted * 4, 32'h0);
      if (last_acc) accepted++;
      else stalls++;
      n++;
    end
    if (accepted < 5) fail("fill_accepts");
    drain();
    check("fill_pulses", pulse_data.size(), 5);
    if (pulse_data.size() == 5)
      for (int i = 0; i < 5; i++) check($sformatf("fill_order%0d", i), pulse_data[i], mem[i]);
`ifndef SRAM_LIKE_RANDSTALL_EN
    check("fill_stall_cycles", stalls, DELAY - MAX_OUTST + 1);
`endif

    // reset while three requests are in flight
    pulse_data.delete(); pulse_edges.delete();
    for (int i = 0; i < 3; i++) issue(1'b0, 2'd2, 32'h40 + i * 4, 32'h0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < DELAY + 4; i++) idle();
    check("midflight_rst_pulses", pulse_data.size(), 0);
    issue(1'b0, 2'd2, 32'h0, 32'h0);
    drain();

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic        r, q, w;
      logic [1:0]  s;
      logic [31:0] a;
      r = ($urandom % 300) == 0;
      q = ($urandom % 10) < 7;
      w = $urandom % 2;
      s = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
      a = ($urandom & 32'hFFFF_FFFC) | ((($urandom % 4) == 0) ? ($urandom % 4) : 0);
      step(r, q, w, s, a, $urandom);
    end
    drain();
    check("final_queue_empty", mq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
